cmd_exec_ctrl: RTL and testbench
================================

# cmd_exec_ctrl

Command execution controller between the command FIFO and the on-chip memory. It pops gathered UART commands from the command FIFO, decodes the opcode, and performs a single write or read memory access. It then pushes an acknowledge byte or the read-data bytes into the response FIFO that feeds the UART transmitter. It is the only sequencer of the memory port and of the response FIFO write side.

## Interface
Parameters:
- `ADDR_W`, 16, memory word-address width
- `DATA_W`, 32, memory data width; must be a multiple of 8
- `MEM_DEPTH`, 1024, number of valid memory words (used only by the address-check feature)
- `MEM_RD_LAT`, 1, memory read latency in cycles; must be at least 1
- Derived: `CMD_W` = 8+`ADDR_W`+`DATA_W`, `NBYTES` = `DATA_W`/8

Ports:
- `clk`  in  1  single clock for the block; all logic is rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_fifo_empty`  in  1  command FIFO has no entries
- `cmd_fifo_rd_en`  out  1  pop strobe; data is valid the cycle after
- `cmd_fifo_rd_data`  in  CMD_W  {opcode[7:0], addr, wdata}, opcode in the MSBs
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`  out  1  write qualifier for `mem_en`
- `mem_addr`  out  ADDR_W  access address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid `MEM_RD_LAT` cycles after `mem_en`
- `resp_fifo_full`  in  1  response FIFO cannot accept a write
- `resp_fifo_wr_en`  out  1  response byte push
- `resp_fifo_wr_data`  out  8  response byte
- `busy`  out  1  high in every state except IDLE
- `err_cnt`  out  8  saturating count of rejected commands

## Operation
Opcodes:
- 0x57 ('W'): write `wdata` to `addr`. Response is 0x4B ('K').
- 0x52 ('R'): read `addr`. Response is `NBYTES` bytes, MSB byte first.
- Any other opcode: no memory access. Response is 0x45 ('E') and `err_cnt` increments, saturating at 255.

FSM states and transitions:
- IDLE: if `!cmd_fifo_empty`, pulse `cmd_fifo_rd_en` and go to FETCH.
- FETCH: latch opcode, addr and wdata from `cmd_fifo_rd_data`, then go to EXEC.
- EXEC:
  - 'W': `mem_en`=1, `mem_we`=1, then go to RESP with the ack byte loaded.
  - 'R': `mem_en`=1, `mem_we`=0, then go to RD_WAIT.
  - Other opcode: go to RESP with 'E' loaded and increment `err_cnt`.
- RD_WAIT: count `MEM_RD_LAT` cycles. Capture `mem_rdata` into the response shift register on the final cycle, then go to RESP.
- RESP: hold until `!resp_fifo_full`, then assert `resp_fifo_wr_en` for one cycle per byte.
  - Shift the register 8 bits left after each byte.
  - After the last byte, go to IDLE.

Outputs and counters:
- `mem_addr` and `mem_wdata` are driven from the latched fields. They hold stable outside EXEC; only `mem_en` qualifies them.
- Internal byte counter width is clog2(`NBYTES`)+1. It loads with 1 for ack/error responses and with `NBYTES` for reads.

## Timing
Reset:
- While `rst`=1, all outputs are 0, the FSM is in IDLE and `err_cnt`=0.
- Reset asserted mid-command abandons the command immediately: no further memory access, no remaining response bytes. A command already popped is lost.

Latencies, with `rd_en` in cycle t and no back-pressure:
- Write: `mem_en` in t+2, 'K' push in t+3.
- Read: `mem_en` in t+2, data bytes pushed in t+3+`MEM_RD_LAT` through t+2+`MEM_RD_LAT`+`NBYTES`.

Handshake rules:
- `cmd_fifo_rd_en` is never asserted while `cmd_fifo_empty`=1, and never outside IDLE. At most one command is in flight.
- `resp_fifo_wr_en` is never asserted while `resp_fifo_full`=1. A full FIFO stalls RESP indefinitely with no bytes dropped; `busy` stays 1.
- The earliest next pop is the cycle after the last response push. Peak throughput for back-to-back writes is one command per 4 cycles.

## Configuration
`CMD_EXEC_ADDR_CHECK_EN`:
- Defined: in EXEC, a 'W' or 'R' with `addr` ≥ `MEM_DEPTH` is treated as an error. There is no `mem_en`, the response is 'E' and `err_cnt` increments.
- Undefined: no range check; the address is passed through unmodified and `MEM_DEPTH` is unused.

## Test plan
- Write 0x57_0010_DEADBEEF, FIFO never full -> one `mem_en`/`mem_we` pulse with addr 0x0010 and data 0xDEADBEEF, then a single push of 0x4B.
- After that write, read 0x52_0010_xxxxxxxx with memory model latency 1 -> one `mem_en` with `mem_we`=0, then pushes 0xDE, 0xAD, 0xBE, 0xEF on consecutive cycles.
- Same read with `resp_fifo_full` held high for 5 cycles after the first byte -> no `wr_en` while full, all 4 bytes delivered in order, `busy`=1 throughout.
- Opcode 0x33 -> no `mem_en`, push 0x45, `err_cnt`=1. After 300 bad commands `err_cnt`=255.
- With `CMD_EXEC_ADDR_CHECK_EN` and `MEM_DEPTH`=1024, write to addr 0x0400 -> no `mem_en`, push 0x45. Write to 0x03FF -> normal 'K'.
- Assert `rst` during the RESP byte stream of a read -> outputs 0 immediately, no further pushes. After release with the FIFO empty, the block stays in IDLE with `busy`=0.

Source files
------------

// File: rtl/cmd_exec_ctrl.sv
// Command execution controller: pops commands, performs one memory write/read, and pushes the response bytes.
// Optional CMD_EXEC_ADDR_CHECK_EN rejects W/R commands whose address is >= MEM_DEPTH.
module cmd_exec_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_RD_LAT = 1,
    localparam int CMD_W     = 8 + ADDR_W + DATA_W,
    localparam int NBYTES    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_fifo_empty,
    output logic              cmd_fifo_rd_en,
    input  logic [CMD_W-1:0]  cmd_fifo_rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              resp_fifo_full,
    output logic              resp_fifo_wr_en,
    output logic [7:0]        resp_fifo_wr_data,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam int LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // Single-byte responses sit in the top byte so the common shift path emits them.
    localparam logic [DATA_W-1:0] ACK_WORD = DATA_W'(RSP_ACK) << (DATA_W - 8);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(RSP_ERR) << (DATA_W - 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [7:0]          r_opcode;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [7:0]          r_err_cnt;

    logic                w_addr_bad;
    logic                w_is_wr;
    logic                w_is_rd;

`ifdef CMD_EXEC_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
    assign w_addr_bad = ({1'b0, r_addr} >= DEPTH_EXT);
`else
    assign w_addr_bad = 1'b0;
`endif

    assign w_is_wr = (r_opcode == OP_WR) && !w_addr_bad;
    assign w_is_rd = (r_opcode == OP_RD) && !w_addr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // rd_en is combinational so the pop lands in the IDLE cycle; rst gates it while reset is held.
    always_comb begin
        w_next          = r_state;
        cmd_fifo_rd_en  = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        resp_fifo_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cmd_fifo_empty && !rst) begin
                    cmd_fifo_rd_en = 1'b1;
                    w_next         = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_wr) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    w_next = S_RESP;
                end else if (w_is_rd) begin
                    mem_en = 1'b1;
                    w_next = S_RD_WAIT;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (!resp_fifo_full) begin
                    resp_fifo_wr_en = 1'b1;
                    if (r_byte_cnt == CNT_W'(1)) begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_lat_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    {r_opcode, r_addr, r_wdata} <= cmd_fifo_rd_data;
                end
                S_EXEC: begin
                    if (w_is_wr) begin
                        r_shift    <= ACK_WORD;
                        r_byte_cnt <= CNT_W'(1);
                    end else if (w_is_rd) begin
                        r_byte_cnt <= CNT_W'(NBYTES);
                        r_lat_cnt  <= LAT_W'(MEM_RD_LAT - 1);
                    end else begin
                        r_shift    <= ERR_WORD;
                        r_byte_cnt <= CNT_W'(1);
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_shift <= mem_rdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                S_RESP: begin
                    if (!resp_fifo_full) begin
                        r_shift    <= r_shift << 8;
                        r_byte_cnt <= r_byte_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr          = r_addr;
    assign mem_wdata         = r_wdata;
    assign resp_fifo_wr_data = r_shift[DATA_W-1 -: 8];
    assign busy              = (r_state != S_IDLE);
    assign err_cnt           = r_err_cnt;

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Testbench for cmd_exec_ctrl: FIFO/memory environment, a queue-based reference model, and randomized traffic.
module tb_cmd_exec_ctrl;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int RD_LAT    = 1;
    localparam int NB        = DATA_W / 8;
    localparam int CMD_W     = 8 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_fifo_empty = 1'b1;
    logic              cmd_fifo_rd_en;
    logic [CMD_W-1:0]  cmd_fifo_rd_data = '0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              resp_fifo_full = 1'b0;
    logic              resp_fifo_wr_en;
    logic [7:0]        resp_fifo_wr_data;
    logic              busy;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    cmd_exec_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_RD_LAT (RD_LAT)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_fifo_empty    (cmd_fifo_empty),
        .cmd_fifo_rd_en    (cmd_fifo_rd_en),
        .cmd_fifo_rd_data  (cmd_fifo_rd_data),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .resp_fifo_full    (resp_fifo_full),
        .resp_fifo_wr_en   (resp_fifo_wr_en),
        .resp_fifo_wr_data (resp_fifo_wr_data),
        .busy              (busy),
        .err_cnt           (err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Environment: command FIFO, memory, response FIFO sink.
    typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;

    int                cyc = 0;
    logic [CMD_W-1:0]  cmd_q[$];
    bit                pop_pending = 0;
    logic [DATA_W-1:0] env_mem[int];
    rd_t               rd_q[$];
    logic [7:0]        got_q[$];
    int                got_cyc_q[$];
    logic [48:0]       acc_q[$];
    int                acc_cyc_q[$];
    int                pop_cyc_q[$];
    int                full_mode = 0;
    int                stall_left = 0;
    bit                stall_go = 0;
    int                viol_rd = 0;
    int                viol_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pop_pending) begin
            if (cmd_q.size() > 0) cmd_fifo_rd_data = cmd_q.pop_front();
            pop_pending = 0;
        end
        cmd_fifo_empty = (cmd_q.size() == 0);
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mem_rdata = rd_q[0].d;
            rd_q.delete(0);
        end else begin
            mem_rdata = $urandom;
        end
        case (full_mode)
            1: resp_fifo_full = ($urandom_range(0, 3) == 0);
            2: begin
                if (stall_go && stall_left > 0) begin
                    resp_fifo_full = 1'b1;
                    stall_left--;
                end else begin
                    resp_fifo_full = 1'b0;
                end
            end
            default: resp_fifo_full = 1'b0;
        endcase
        #1;
        if (cmd_fifo_rd_en) begin
            if (cmd_fifo_empty || busy) viol_rd++;
            pop_pending = 1;
            pop_cyc_q.push_back(cyc);
        end
        if (mem_en) begin
            acc_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
            acc_cyc_q.push_back(cyc);
            if (mem_we) begin
                env_mem[int'(mem_addr)] = mem_wdata;
            end else begin
                rd_q.push_back('{cyc + RD_LAT,
                    env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : 32'h0});
            end
        end
        if (resp_fifo_wr_en) begin
            if (resp_fifo_full) viol_wr++;
            got_q.push_back(resp_fifo_wr_data);
            got_cyc_q.push_back(cyc);
            if (full_mode == 2) stall_go = 1;
        end
    end

    // Reference model: what the response stream, memory accesses and error count should be.
    logic [DATA_W-1:0] ref_mem[int];
    logic [7:0]        exp_bytes[$];
    logic [48:0]       exp_acc[$];
    int                ref_err = 0;

    function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
`ifdef CMD_EXEC_ADDR_CHECK_EN
        return int'(a) < MEM_DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model(input logic [7:0] op, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] v;
        if (op == 8'h57 && addr_ok(a)) begin
            ref_mem[int'(a)] = d;
            exp_acc.push_back({1'b1, a, d});
            exp_bytes.push_back(8'h4B);
        end else if (op == 8'h52 && addr_ok(a)) begin
            v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
            exp_acc.push_back({1'b0, a, 32'h0});
            for (int i = NB - 1; i >= 0; i--) exp_bytes.push_back(v[8*i +: 8]);
        end else begin
            exp_bytes.push_back(8'h45);
            if (ref_err < 255) ref_err++;
        end
    endfunction

    task automatic send(input logic [7:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_q.push_back({op, a, d});
        model(op, a, d);
    endtask

    task automatic wait_idle(input int max_cyc);
        int stable = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #2;
            if (cmd_q.size() == 0 && cmd_fifo_empty && !pop_pending && !busy) stable++;
            else stable = 0;
            if (stable >= 3) return;
        end
        check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic compare_phase(input string tag);
        while (exp_bytes.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, "_missing_bytes"}, 64'd0, 64'(exp_bytes.size()));
                exp_bytes.delete();
                break;
            end
            check({tag, "_byte"}, 64'(got_q.pop_front()), 64'(exp_bytes.pop_front()));
        end
        if (got_q.size() > 0) check({tag, "_extra_bytes"}, 64'(got_q.size()), 64'd0);
        while (exp_acc.size() > 0) begin
            if (acc_q.size() == 0) begin
                check({tag, "_missing_acc"}, 64'd0, 64'(exp_acc.size()));
                exp_acc.delete();
                break;
            end
            check({tag, "_mem_acc"}, 64'(acc_q.pop_front()), 64'(exp_acc.pop_front()));
        end
        if (acc_q.size() > 0) check({tag, "_extra_acc"}, 64'(acc_q.size()), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(ref_err));
        got_q.delete();
        got_cyc_q.delete();
        acc_q.delete();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]        op;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        int                busy_lo;
        int                t0;

        // Reset held with a command already waiting: nothing may be popped.
        send(8'h57, 16'h0010, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_outputs_zero", 64'(|{cmd_fifo_rd_en, mem_en, mem_we, mem_addr, mem_wdata,
              resp_fifo_wr_en, resp_fifo_wr_data, busy, err_cnt}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed write latency.
        wait_idle(100);
        check("wr_pop_seen", 64'(pop_cyc_q.size()), 64'd1);
        check("wr_acc_seen", 64'(acc_cyc_q.size()), 64'd1);
        check("wr_push_seen", 64'(got_cyc_q.size()), 64'd1);
        if (pop_cyc_q.size() > 0 && acc_cyc_q.size() > 0 && got_cyc_q.size() > 0) begin
            t0 = pop_cyc_q[0];
            check("wr_mem_en_lat", 64'(acc_cyc_q[0] - t0), 64'd2);
            check("wr_push_lat", 64'(got_cyc_q[0] - t0), 64'd3);
        end
        compare_phase("wr");

        // Directed read latency and byte order.
        send(8'h52, 16'h0010, $urandom);
        wait_idle(100);
        check("rd_push_count", 64'(got_cyc_q.size()), 64'(NB));
        if (pop_cyc_q.size() > 0 && got_cyc_q.size() == NB) begin
            t0 = pop_cyc_q[0];
            check("rd_first_lat", 64'(got_cyc_q[0] - t0), 64'(3 + RD_LAT));
            check("rd_span", 64'(got_cyc_q[NB-1] - got_cyc_q[0]), 64'(NB - 1));
        end
        compare_phase("rd");

        // Read stalled for 5 cycles after its first byte.
        full_mode = 2;
        stall_left = 5;
        stall_go = 0;
        send(8'h52, 16'h0010, $urandom);
        busy_lo = 0;
        for (int i = 0; i < 80 && got_q.size() < NB; i++) begin
            @(negedge clk);
            #2;
            if (got_q.size() >= 1 && got_q.size() < NB && !busy) busy_lo++;
        end
        check("stall_bytes", 64'(got_q.size()), 64'(NB));
        check("stall_busy_low", 64'(busy_lo), 64'd0);
        if (got_cyc_q.size() == NB)
            check("stall_span", 64'(got_cyc_q[NB-1] - got_cyc_q[0]), 64'(NB - 1 + 5));
        wait_idle(100);
        compare_phase("stall");
        full_mode = 0;

        // Bad opcode.
        send(8'h33, 16'h0020, 32'h12345678);
        wait_idle(100);
        compare_phase("badop");

        // Address boundary around MEM_DEPTH.
        send(8'h57, 16'h0400, 32'hA5A5A5A5);
        send(8'h57, 16'h03FF, 32'h0BADF00D);
        send(8'h52, 16'h03FF, 32'h0);
        wait_idle(200);
        compare_phase("addr_edge");

        // Back-to-back writes: one command per 4 cycles.
        for (int i = 0; i < 5; i++) send(8'h57, 16'(i + 1), $urandom);
        wait_idle(200);
        check("b2b_pops", 64'(pop_cyc_q.size()), 64'd5);
        if (pop_cyc_q.size() == 5)
            for (int i = 1; i < 5; i++) check("b2b_spacing", 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'd4);
        compare_phase("b2b");

        // Randomized traffic with random back-pressure.
        full_mode = 1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 8'h57;
                4, 5, 6, 7: op = 8'h52;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                end
            endcase
            a = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            send(op, a, $urandom);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(5000);
        compare_phase("rand");
        full_mode = 0;

        // Error counter saturation.
        for (int i = 0; i < 300; i++) send(8'hA0 + 8'(i % 16), 16'(i), 32'h0);
        wait_idle(5000);
        check("err_sat", 64'(err_cnt), 64'd255);
        compare_phase("sat");

        // Reset in the middle of a read response stream.
        v = ref_mem.exists(16) ? ref_mem[16] : '0;
        cmd_q.push_back({8'h52, 16'h0010, 32'h0});
        exp_acc.push_back({1'b0, 16'h0010, 32'h0});
        exp_bytes.push_back(v[31:24]);
        exp_bytes.push_back(v[23:16]);
        for (int i = 0; i < 60 && got_q.size() < 2; i++) begin
            @(negedge clk);
            #2;
        end
        check("mid_rst_reached", 64'(got_q.size()), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs_zero", 64'(|{cmd_fifo_rd_en, mem_en, mem_we, mem_addr, mem_wdata,
              resp_fifo_wr_en, resp_fifo_wr_data, busy, err_cnt}), 64'd0);
        ref_err = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_no_pop", 64'(pop_cyc_q.size()), 64'd1);
        compare_phase("mid_rst");

        check("rd_en_violations", 64'(viol_rd), 64'd0);
        check("wr_en_while_full", 64'(viol_wr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
